ppu_seq_ctrl: RTL and testbench

PPU_SEQ_CTRL -- requirements
Module: ppu_seq_ctrl

---
 rtl/ppu_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_ppu_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ppu_seq_ctrl
// Description : Sequencer for one post-processing pass. It streams len
//               32-bit psums out of the psum buffer, passes each through the
//               post-processing unit (PPU), packs the returned quantized bytes
//               four per word and writes the words into the ofmap buffer.
//
// Ports       : clk, rst            clock, synchronous active-high reset
//               start, len,         pass request and its parameters, all
//               src_base, dst_base, sampled in the cycle start is accepted
//               scale_in
//               psum_rd_en/_addr    psum-buffer read (data one cycle later)
//               psum_rd_data        psum-buffer read data
//               ppu_en/_data/_scale PPU drive
//               ppu_valid/_byte     PPU result, one cycle after ppu_en
//               ofm_wr_en/_addr/    ofmap-buffer word write with byte strobes
//               _data/_strb
//               busy, done          pass active / one-cycle completion pulse
//               cycle_cnt           busy-cycle counter (PPU_SEQ_PERF_EN only)
//
// Options     : `define PPU_SEQ_PERF_EN adds the cycle_cnt output.
//
// Revision    : 1.0  initial release
// ============================================================================
module ppu_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [11:0] src_base,
    input  logic [11:0] dst_base,
    input  logic [11:0] scale_in,
    output logic        psum_rd_en,
    output logic [11:0] psum_rd_addr,
    input  logic [31:0] psum_rd_data,
    output logic        ppu_en,
    output logic [31:0] ppu_data,
    output logic [11:0] ppu_scale,
    input  logic        ppu_valid,
    input  logic [7:0]  ppu_byte,
    output logic        ofm_wr_en,
    output logic [11:0] ofm_wr_addr,
    output logic [31:0] ofm_wr_data,
    output logic [3:0]  ofm_wr_strb,
    output logic        busy,
`ifdef PPU_SEQ_PERF_EN
    output logic [31:0] cycle_cnt,
`endif
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] rd_left;     // reads still to issue after the current one
    logic [15:0] rx_left;     // PPU bytes still expected in this pass
    logic [1:0]  lane;        // lane the next received byte lands in
    logic [23:0] pack;        // lanes 0..2 of the word being assembled
    logic [11:0] wr_ptr;      // next ofmap word address

    logic        take;        // a PPU byte belonging to this pass arrives
    logic        last_byte;
    logic [31:0] word;        // packed word including the arriving byte
    logic [3:0]  fill_strb;   // lanes 0..lane filled

    // PPU data is a straight pass-through of the read data, forced to zero
    // whenever no read is returning so the path reads 0 out of reset.
    assign ppu_data = ppu_en ? psum_rd_data : 32'd0;

    // Bytes are accepted only while a pass is collecting them; stray
    // ppu_valid pulses outside ISSUE/DRAIN, or beyond len, are dropped.
    assign take      = ppu_valid && (rx_left != 16'd0)
                       && ((state == ISSUE) || (state == DRAIN));
    assign last_byte = (rx_left == 16'd1);

    always_comb begin
        word                       = {8'd0, pack};
        word[{lane, 3'b000} +: 8]  = ppu_byte;
        case (lane)
            2'd0:    fill_strb = 4'b0001;
            2'd1:    fill_strb = 4'b0011;
            2'd2:    fill_strb = 4'b0111;
            default: fill_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rd_left      <= 16'd0;
            rx_left      <= 16'd0;
            lane         <= 2'd0;
            pack         <= 24'd0;
            wr_ptr       <= 12'd0;
            psum_rd_en   <= 1'b0;
            psum_rd_addr <= 12'd0;
            ppu_en       <= 1'b0;
            ppu_scale    <= 12'd0;
            ofm_wr_en    <= 1'b0;
            ofm_wr_addr  <= 12'd0;
            ofm_wr_data  <= 32'd0;
            ofm_wr_strb  <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            ofm_wr_en <= 1'b0;
            done      <= 1'b0;
            ppu_en    <= psum_rd_en;

            // Byte packing. A word is written the cycle after its lane 3
            // fills, or after the final byte of the pass for a partial word;
            // unfilled lanes are zero because pack is cleared after a write.
            if (take) begin
                rx_left <= rx_left - 16'd1;
                lane    <= lane + 2'd1;
                if ((lane == 2'd3) || last_byte) begin
                    ofm_wr_en   <= 1'b1;
                    ofm_wr_addr <= wr_ptr;
                    ofm_wr_data <= word;
                    ofm_wr_strb <= fill_strb;
                    wr_ptr      <= wr_ptr + 12'd1;
                    pack        <= 24'd0;
                end else begin
                    pack <= word[23:0];
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        ppu_scale <= scale_in;
                        wr_ptr    <= dst_base;
                        lane      <= 2'd0;
                        pack      <= 24'd0;
                        rx_left   <= len;
                        busy      <= 1'b1;
                        if (len == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            psum_rd_en   <= 1'b1;
                            psum_rd_addr <= src_base;
                            rd_left      <= len - 16'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (rd_left == 16'd0) begin
                        psum_rd_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        psum_rd_addr <= psum_rd_addr + 12'd1;
                        rd_left      <= rd_left - 16'd1;
                    end
                end
                DRAIN: begin
                    // The final byte's write (full or partial) is issued on
                    // this same edge and is visible during FLUSH.
                    if (take && last_byte) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PPU_SEQ_PERF_EN
    // Counts busy cycles of the latest pass; holds its value once idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
        end else if ((state == IDLE) && start) begin
            cycle_cnt <= 32'd0;
        end else if (busy) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_seq_ctrl
// Description : Self-checking bench for ppu_seq_ctrl. A psum-buffer and PPU
//               stub surround the DUT; a transaction-level reference model
//               predicts reads, writes, done timing and busy duration.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ppu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [11:0] src_base, dst_base, scale_in;
    logic        psum_rd_en;
    logic [11:0] psum_rd_addr;
    logic [31:0] psum_rd_data = 32'd0;
    logic        ppu_en;
    logic [31:0] ppu_data;
    logic [11:0] ppu_scale;
    logic        ppu_valid = 1'b0;
    logic [7:0]  ppu_byte = 8'd0;
    logic        ofm_wr_en;
    logic [11:0] ofm_wr_addr;
    logic [31:0] ofm_wr_data;
    logic [3:0]  ofm_wr_strb;
    logic        busy, done;
`ifdef PPU_SEQ_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    ppu_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .scale_in     (scale_in),
        .psum_rd_en   (psum_rd_en),
        .psum_rd_addr (psum_rd_addr),
        .psum_rd_data (psum_rd_data),
        .ppu_en       (ppu_en),
        .ppu_data     (ppu_data),
        .ppu_scale    (ppu_scale),
        .ppu_valid    (ppu_valid),
        .ppu_byte     (ppu_byte),
        .ofm_wr_en    (ofm_wr_en),
        .ofm_wr_addr  (ofm_wr_addr),
        .ofm_wr_data  (ofm_wr_data),
        .ofm_wr_strb  (ofm_wr_strb),
        .busy         (busy),
`ifdef PPU_SEQ_PERF_EN
        .cycle_cnt    (cycle_cnt),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:4095];

    typedef struct { int cyc; int addr; } rd_t;
    typedef struct { int cyc; int addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    rd_t rd_q[$];
    wr_t wr_q[$];
    int  done_q[$];
    int  busy_n;

    // Stand-in quantizer used by both the PPU stub and the model.
    function automatic logic [7:0] quant(input logic [31:0] d, input logic [11:0] sc);
        return d[7:0] ^ d[15:8] ^ sc[7:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Psum buffer (one-cycle read latency) and PPU (one-cycle result).
    always @(posedge clk) begin
        psum_rd_data <= psum_rd_en ? mem[psum_rd_addr] : $urandom;
        ppu_valid    <= ppu_en;
        ppu_byte     <= quant(ppu_data, ppu_scale);
    end

    // Event recorder, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (psum_rd_en) rd_q.push_back('{cyc, int'(psum_rd_addr)});
        if (ofm_wr_en)  wr_q.push_back('{cyc, int'(ofm_wr_addr), ofm_wr_data, ofm_wr_strb});
        if (done)       done_q.push_back(cyc);
        if (busy)       busy_n++;
    end

    function automatic logic any_output_set();
        logic v;
        v = psum_rd_en | (|psum_rd_addr) | ppu_en | (|ppu_data) | (|ppu_scale)
          | ofm_wr_en | (|ofm_wr_addr) | (|ofm_wr_data) | (|ofm_wr_strb) | busy | done;
`ifdef PPU_SEQ_PERF_EN
        v = v | (|cycle_cnt);
`endif
        return v;
    endfunction

    task automatic clear_rec();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_n = 0;
    endtask

    // Runs one pass starting in the current cycle; returns in the done cycle.
    // restart > 0 pulses a junk start at that relative cycle.
    task automatic run_pass(input int l, input int s, input int d, input int sc, input int restart);
        int c0, exp_done, nw, nb, n;
        logic [31:0] ew;
        clear_rec();
        start = 1'b1; len = 16'(l); src_base = 12'(s); dst_base = 12'(d); scale_in = 12'(sc);
        c0 = cyc;
        exp_done = (l == 0) ? 1 : l + 4;
        for (int r = 1; r <= exp_done; r++) begin
            @(negedge clk);
            if (r == restart) begin
                start = 1'b1; len = 16'($urandom); src_base = 12'($urandom);
                dst_base = 12'($urandom); scale_in = 12'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        // Reads: one per psum at consecutive wrapped addresses, cycles 1..len.
        check_eq("rd_count", rd_q.size(), l);
        n = (rd_q.size() < l) ? rd_q.size() : l;
        for (int i = 0; i < n; i++) begin
            check_eq("rd_addr", rd_q[i].addr, (s + i) % 4096);
            check_eq("rd_cycle", rd_q[i].cyc - c0, i + 1);
        end

        // Writes: byte k = quant(psum k); word w holds bytes 4w..4w+3.
        nw = (l + 3) / 4;
        check_eq("wr_count", wr_q.size(), nw);
        n = (wr_q.size() < nw) ? wr_q.size() : nw;
        for (int w = 0; w < n; w++) begin
            nb = (l - 4 * w >= 4) ? 4 : l - 4 * w;
            ew = 32'd0;
            for (int j = 0; j < nb; j++)
                ew[8*j +: 8] = quant(mem[(s + 4 * w + j) % 4096], 12'(sc));
            check_eq("wr_addr", wr_q[w].addr, (d + w) % 4096);
            check_eq("wr_data", wr_q[w].data, ew);
            check_eq("wr_strb", wr_q[w].strb, (1 << nb) - 1);
            check_eq("wr_cycle", wr_q[w].cyc - c0, (nb == 4) ? 4 * w + 7 : l + 3);
        end

        check_eq("done_count", done_q.size(), 1);
        if (done_q.size() > 0) check_eq("done_cycle", done_q[0] - c0, exp_done);
        check_eq("busy_cycles", busy_n, exp_done);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 16'd0;
        src_base = 12'd0; dst_base = 12'd0; scale_in = 12'd0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", any_output_set(), 1'b0);
        rst = 1'b0;

        // Bytes 1..8 with scale 0.
        for (int i = 0; i < 8; i++) mem[100 + i] = 32'(i + 1);
        @(negedge clk); run_pass(8, 100, 200, 0, 0);
        if (wr_q.size() > 0) check_eq("len8_word0", wr_q[0].data, 32'h04030201);
        if (wr_q.size() > 1) check_eq("len8_word1", wr_q[1].data, 32'h08070605);
        @(negedge clk); run_pass(5, 100, 300, 0, 0);
        if (wr_q.size() > 1) check_eq("len5_partial", wr_q[1].data, 32'h00000005);
        @(negedge clk); run_pass(0, 10, 20, 3, 0);
`ifdef PPU_SEQ_PERF_EN
        @(negedge clk);
        check_eq("cycle_cnt_len0", cycle_cnt, 32'd1);
`endif

        // Start pulse during ISSUE is ignored.
        @(negedge clk); run_pass(8, 500, 600, 77, 2);
        // Address wrap on both buffers.
        @(negedge clk); run_pass(8, 4094, 4095, 19, 0);

        // Random passes, including back-to-back starts.
        for (int p = 0; p < 12; p++) begin
            repeat ($urandom_range(0, 2) + 1) @(negedge clk);
            run_pass($urandom_range(0, 21), $urandom_range(0, 4095),
                     $urandom_range(0, 4095), $urandom_range(0, 4095), 0);
        end

        // Reset in cycle 5 of a len=8 pass.
        @(negedge clk);
        start = 1'b1; len = 16'd8; src_base = 12'd40; dst_base = 12'd80; scale_in = 12'd5;
        for (int r = 1; r <= 5; r++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midpass_reset_outputs", any_output_set(), 1'b0);
        clear_rec();
        repeat (14) @(negedge clk);
        check_eq("post_reset_writes", wr_q.size(), 0);
        check_eq("post_reset_done", done_q.size(), 0);
        check_eq("post_reset_reads", rd_q.size(), 0);

        // Clean pass after reset, then the held perf count.
        run_pass(8, 40, 80, 5, 0);
`ifdef PPU_SEQ_PERF_EN
        @(negedge clk);
        check_eq("cycle_cnt_len8", cycle_cnt, 32'd12);
        repeat (3) @(negedge clk);
        check_eq("cycle_cnt_hold", cycle_cnt, 32'd12);
`endif
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
